cordic_vectoring: RTL and testbench

Iterative vectoring-mode CORDIC that converts a signed Cartesian vector (x, y) into its polar form: the angle atan2(y, x) and the gain-compensated magnitude. It is the inverse of the rotation-mode sine/cosine CORDIC, and it shares the same 16-bit signed angle convention and arctangent-LUT parameterisation. It sits downstream of sample sources that need phase/magnitude recovery. It uses a single shift-add datapath that is reused for LENGTH cycles, with valid/ready handshakes on both sides.

---
 rtl/cordic_vectoring.sv | 144 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative vectoring-mode CORDIC: converts a signed Cartesian vector
//   (x_in, y_in) into angle = atan2(y_in, x_in) (Q3.13 radians) and the
//   gain-compensated magnitude. One shift-add datapath is reused for LENGTH
//   micro-rotations, then one cycle scales x by 1/K.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset (aborts any operation)
//   in_valid   x_in/y_in valid
//   in_ready   vector can be accepted (FSM in IDLE)
//   x_in,y_in  16-bit signed input vector
//   out_valid  angle/mag valid (FSM in DONE)
//   out_ready  consumer accepts result
//   angle      16-bit signed Q3.13 radians, [-pi, +pi]
//   mag        17-bit unsigned magnitude, same scale as inputs
module cordic_vectoring #(
  parameter int                LENGTH               = 14,
  parameter logic signed [15:0] ATAN_LUT [0:LENGTH-1] = '{
    16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128,
    16'sd64,   16'sd32,   16'sd16,   16'sd8,    16'sd4,   16'sd2,   16'sd1},
  parameter logic signed [15:0] HALF_PI              = 16'sd12868,
  parameter logic signed [15:0] GAIN                 = 16'sd19898
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] angle,
  output logic        [16:0] mag
);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  localparam logic [3:0] LAST = 4'(LENGTH - 1);

  state_t             state_q, state_d;
  logic        [3:0]  i_q, i_d;
  logic signed [17:0] x_q, x_d, y_q, y_d;
  logic signed [15:0] z_q, z_d;
  logic               zero_q, zero_d;
  logic signed [15:0] angle_q, angle_d;
  logic        [16:0] mag_q, mag_d;

  // Sign-extend before any negation so -(-32768) is representable.
  logic signed [17:0] xe, ye;
  logic signed [17:0] xs, ys;
  logic signed [15:0] step;
  logic signed [33:0] prod;

  assign xe   = {{2{x_in[15]}}, x_in};
  assign ye   = {{2{y_in[15]}}, y_in};
  assign xs   = x_q >>> i_q;
  assign ys   = y_q >>> i_q;
  assign step = ATAN_LUT[i_q];
  assign prod = 34'(x_q) * 34'(GAIN);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ITER;
          i_d     = '0;
          // (0,0) has no defined direction; the iterations would still
          // accumulate angle, so force the reported angle to zero.
          zero_d  = (x_in == 16'sd0) && (y_in == 16'sd0);
          // Pre-rotate left-half-plane vectors by -/+90 deg so the
          // iterations only ever have to cover [-pi/2, pi/2].
          if (!x_in[15]) begin
            x_d = xe;  y_d = ye;  z_d = '0;
          end else if (!y_in[15]) begin
            x_d = ye;  y_d = -xe; z_d = HALF_PI;
          end else begin
            x_d = -ye; y_d = xe;  z_d = -HALF_PI;
          end
        end
      end
      ITER: begin
        // Drive y toward zero; z accumulates the rotation undone.
        if (!y_q[17]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + step;
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - step;
        end
        i_d = i_q + 4'd1;
        if (i_q == LAST) state_d = SCALE;
      end
      SCALE: begin
        // x is non-negative here, so the truncated product fits 17 bits.
        mag_d   = 17'(prod >>> 15);
        angle_d = zero_q ? 16'sd0 : z_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign angle     = angle_q;
  assign mag       = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

  localparam int  LAT    = 15;
  localparam real SCL    = 8192.0;
  localparam real PI_S   = 3.14159265358979 * 8192.0;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in, y_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] angle;
  logic        [16:0] mag;

  cordic_vectoring dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready), .angle(angle), .mag(mag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    real   ea;
    real   em;
    int    ta;
    int    tm;
    int    acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", msg);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit busy = 0, seen = 0, hold = 0, rdy_chk = 0;
  logic signed [15:0] hold_a;
  logic        [16:0] hold_m;

  always @(negedge clk) begin
    if (rst) begin
      busy = 0; seen = 0; hold = 0; rdy_chk = 0;
    end else begin
      if (rdy_chk)
        chk(in_ready && !out_valid, $sformatf(
          "ready_after_hs in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid));
      rdy_chk = 0;
      if (hold)
        chk(out_valid && angle == hold_a && mag == hold_m, $sformatf(
          "backpressure_hold valid=%0b angle=%0d mag=%0d want 1/%0d/%0d",
          out_valid, angle, mag, hold_a, hold_m));
      if (busy)
        chk(!in_ready, $sformatf("busy_in_ready got=%0b want 0", in_ready));
      if (out_valid && !seen) begin
        seen = 1; hold_a = angle; hold_m = mag;
        if (exp_q.size() == 0) begin
          chk(1'b0, $sformatf("unexpected_out_valid angle=%0d mag=%0d want none", angle, mag));
        end else begin
          exp_t e;
          real  d;
          e = exp_q.pop_front();
          chk(cyc - e.acc == LAT, $sformatf("%s latency got=%0d want %0d",
              e.nm, cyc - e.acc, LAT));
          d = real'(angle) - e.ea;
          if (d >  PI_S) d = d - 2.0 * PI_S;
          if (d < -PI_S) d = d + 2.0 * PI_S;
          chk(d <= e.ta && d >= -e.ta, $sformatf("%s angle got=%0d want %0.2f tol %0d",
              e.nm, angle, e.ea, e.ta));
          d = real'(mag) - e.em;
          chk(d <= e.tm && d >= -e.tm, $sformatf("%s mag got=%0d want %0.2f tol %0d",
              e.nm, mag, e.em, e.tm));
        end
      end
      hold = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        seen = 0; busy = 0; rdy_chk = 1;
      end
      if (in_valid && in_ready) busy = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                      input real ea, input real em, input int ta, input int tm,
                      input string nm, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk(in_ready, $sformatf("%s accept_wait in_ready=%0b want 1", nm, in_ready));
    x_in = x; y_in = y; in_valid = 1'b1;
    if (push) begin
      exp_t e;
      e.nm = nm; e.ea = ea; e.em = em; e.ta = ta; e.tm = tm; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk(exp_q.size() == 0 && in_ready, $sformatf("%s done_wait pending=%0d in_ready=%0b want 0/1",
        nm, exp_q.size(), in_ready));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] rx, ry;
    real xr, yr;
    int  n;
    bit  ov;

    rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk(in_ready,   $sformatf("reset in_ready got=%0b want 1", in_ready));
    chk(!out_valid, $sformatf("reset out_valid got=%0b want 0", out_valid));
    chk(angle == 0, $sformatf("reset angle got=%0d want 0", angle));
    chk(mag == 0,   $sformatf("reset mag got=%0d want 0", mag));

    // axis vectors
    send( 16'sd16384,  16'sd0,          0.0, 16384.0, 4, 4, "pos_x",  1); wait_done("pos_x");
    send( 16'sd0,      16'sd16384,  12868.0, 16384.0, 4, 8, "pos_y",  1); wait_done("pos_y");
    send(-16'sd16384,  16'sd0,      25736.0, 16384.0, 4, 8, "neg_x",  1); wait_done("neg_x");
    send( 16'sd0,     -16'sd16384, -12868.0, 16384.0, 4, 8, "neg_y",  1); wait_done("neg_y");
    // diagonals, extremes, zero
    send(-16'sd16384, -16'sd16384, -19302.0, 23170.0, 4, 4, "diag_q3", 1); wait_done("diag_q3");
    rx = -16'sd32768; ry = -16'sd32768;
    send(rx, ry, -19302.0, 46341.0, 4, 8, "max_neg", 1); wait_done("max_neg");
    send(16'sd0, 16'sd0, 0.0, 0.0, 0, 0, "zero", 1); wait_done("zero");
    send(16'sd9000,   16'sd12000,  7596.0, 15000.0, 4, 8, "tri_345",  1); wait_done("tri_345");

    // in_valid pulses while iterating must be ignored
    send(16'sd16384, 16'sd16384, 6434.0, 23170.0, 4, 4, "ignore_iv", 1);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1; x_in = -16'sd100; y_in = 16'sd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1; x_in = 16'sd5; y_in = -16'sd30000;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done("ignore_iv");

    // backpressure: hold out_ready low for 5 cycles in DONE
    out_ready = 1'b0;
    send(-16'sd12000, 16'sd5000, 22502.0, 13000.0, 4, 8, "bp", 1);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk(out_valid, $sformatf("bp out_valid_wait got=%0b want 1", out_valid));
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("bp");

    // reset during iteration 6 aborts the vector
    send(16'sd1000, 16'sd2000, 0.0, 0.0, 0, 0, "abort", 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk(in_ready,   $sformatf("abort in_ready got=%0b want 1", in_ready));
    chk(!out_valid, $sformatf("abort out_valid got=%0b want 0", out_valid));
    chk(angle == 0, $sformatf("abort angle got=%0d want 0", angle));
    chk(mag == 0,   $sformatf("abort mag got=%0d want 0", mag));
    ov = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) ov = 1; end
    chk(!ov, $sformatf("abort no_result out_valid_seen=%0b want 0", ov));
    send(16'sd16384, 16'sd16384, 6434.0, 23170.0, 4, 4, "post_abort", 1);
    wait_done("post_abort");

    // random sweep against a real-valued model
    for (int k = 0; k < 1000; k++) begin
      do begin
        rx = 16'($urandom); ry = 16'($urandom);
        xr = rx; yr = ry;
      end while (xr * xr + yr * yr < 16384.0 * 16384.0);
      send(rx, ry, $atan2(yr, xr) * SCL, $sqrt(xr * xr + yr * yr), 4, 8,
           $sformatf("rnd%0d(%0d,%0d)", k, rx, ry), 1);
    end
    wait_done("rnd_end");

    chk(exp_q.size() == 0, $sformatf("scoreboard_drained pending=%0d want 0", exp_q.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
